// File: rtl/cfg_shift_loader_pkg.sv
// Shared definitions for the configuration chain loader: FSM states,
// length-header width and the payload byte-count helper.
package cfg_shift_loader_pkg;

   localparam int LEN_W = 16;

   typedef enum logic [3:0] {
      ST_LEN_HI    = 4'd0,
      ST_LEN_LO    = 4'd1,
      ST_SETUP     = 4'd2,
      ST_BYTE_WAIT = 4'd3,
      ST_BIT_LO    = 4'd4,
      ST_BIT_HI    = 4'd5,
      ST_TRAIL     = 4'd6,
      ST_DONE      = 4'd7,
      ST_DRAIN     = 4'd8
   } state_e;

   // Number of payload bytes carrying len bits; one spare bit avoids wrap at 16'hFFFF.
   function automatic logic [LEN_W-1:0] ceil_div8(input logic [LEN_W-1:0] len);
      logic [LEN_W:0] sum;
      sum = {1'b0, len} + (LEN_W+1)'(3'd7);
      return LEN_W'(sum >> 3);
   endfunction

endpackage

// File: rtl/cfg_shift_loader_if.sv
// Byte stream valid/ready handshake feeding the configuration loader.
interface cfg_shift_loader_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cfg_bit_serializer.sv
// Byte shifter that emits one bit per BIT_LO/BIT_HI pair, MSB first, with
// registered shift_clk/shift_i strobes for the configuration chain.
module cfg_bit_serializer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   input  logic       lo_i,
   input  logic       hi_i,
   output logic       byte_empty_o,
   output logic       shift_clk_o,
   output logic       shift_i_o
);

   logic [7:0] sh_q, sh_d, src_s;
   logic [3:0] cnt_q, cnt_d, cnt_src_s;
   logic       shift_clk_q, shift_clk_d;
   logic       shift_i_q, shift_i_d;

   // A load replaces any padding bits left over from the previous byte.
   always_comb begin
      src_s       = load_i ? byte_i : sh_q;
      cnt_src_s   = load_i ? 4'd8 : cnt_q;
      sh_d        = src_s;
      cnt_d       = cnt_src_s;
      shift_i_d   = 1'b0;
      shift_clk_d = hi_i;
      if (lo_i) begin
         shift_i_d = src_s[7];
         sh_d      = {src_s[6:0], 1'b0};
         cnt_d     = cnt_src_s - 4'd1;
      end else if (hi_i) begin
         shift_i_d = shift_i_q;
      end else begin
         shift_i_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q        <= 8'd0;
         cnt_q       <= 4'd0;
         shift_clk_q <= 1'b0;
         shift_i_q   <= 1'b0;
      end else begin
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         shift_clk_q <= shift_clk_d;
         shift_i_q   <= shift_i_d;
      end
   end

   assign byte_empty_o = (cnt_q == 4'd0);
   assign shift_clk_o  = shift_clk_q;
   assign shift_i_o    = shift_i_q;

endmodule

// File: rtl/cfg_shift_loader.sv
// Length-prefixed stream loader for the I/O buffer configuration chain:
// header check, payload serialisation under shift_en, drain on length error.
module cfg_shift_loader
   import cfg_shift_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 6
) (
   input  logic              cfg_clk,
   input  logic              cfg_rst_n,
   cfg_shift_loader_if.slave s,
   output logic              shift_clk,
   output logic              shift_en,
   output logic              shift_i,
   input  logic              shift_o,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              prev_parity
);

   localparam int               BIT_W       = $clog2(CHAIN_LEN + 1);
   localparam logic [LEN_W-1:0] CHAIN_LEN_L = LEN_W'(CHAIN_LEN);
   localparam logic [BIT_W-1:0] CHAIN_LEN_B = BIT_W'(CHAIN_LEN);
   localparam logic [LEN_W-1:0] ONE_L       = LEN_W'(1'b1);
   localparam logic [LEN_W-1:0] ZERO_L      = LEN_W'(1'b0);

   state_e           state_q, state_d;
   logic [7:0]       len_hi_q, len_hi_d;
   logic [BIT_W-1:0] bits_q, bits_d;
   logic [LEN_W-1:0] drain_q, drain_d;
   logic             parity_q, parity_d;
   logic             prev_parity_q, prev_parity_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             shift_en_q, shift_en_d;
   logic             s_ready_q, s_ready_d;

   logic             accept_s;
   logic [LEN_W-1:0] len_s;
   logic             len_ok_s;
   logic [LEN_W-1:0] len_bytes_s;
   logic             byte_empty_s;

   assign accept_s    = s.s_valid & s_ready_q;
   assign len_s       = LEN_W'({len_hi_q, s.s_data});
   assign len_ok_s    = (len_s == CHAIN_LEN_L);
   assign len_bytes_s = ceil_div8(len_s);

   cfg_bit_serializer u_ser (
      .clk          (cfg_clk),
      .rst_n        (cfg_rst_n),
      .load_i       ((state_q == ST_BYTE_WAIT) & accept_s),
      .byte_i       (s.s_data),
      .lo_i         (state_d == ST_BIT_LO),
      .hi_i         (state_d == ST_BIT_HI),
      .byte_empty_o (byte_empty_s),
      .shift_clk_o  (shift_clk),
      .shift_i_o    (shift_i)
   );

   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         state_q <= ST_LEN_HI;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LEN_HI:    state_d = accept_s ? ST_LEN_LO : ST_LEN_HI;
         ST_LEN_LO: begin
            if (!accept_s)               state_d = ST_LEN_LO;
            else if (len_ok_s)           state_d = ST_SETUP;
            else if (len_bytes_s == ZERO_L) state_d = ST_LEN_HI;
            else                         state_d = ST_DRAIN;
         end
         ST_SETUP:     state_d = ST_BYTE_WAIT;
         ST_BYTE_WAIT: state_d = accept_s ? ST_BIT_LO : ST_BYTE_WAIT;
         ST_BIT_LO:    state_d = ST_BIT_HI;
         ST_BIT_HI: begin
            if (bits_q == BIT_W'(1'b0)) state_d = ST_TRAIL;
            else if (byte_empty_s)      state_d = ST_BYTE_WAIT;
            else                        state_d = ST_BIT_LO;
         end
         ST_TRAIL:     state_d = ST_DONE;
         ST_DONE:      state_d = ST_LEN_HI;
         ST_DRAIN:     state_d = (accept_s && drain_q == ONE_L) ? ST_LEN_HI : ST_DRAIN;
         default:      state_d = ST_LEN_HI;
      endcase
   end

   // Outputs are registered decodes of the next state so the chain pins never glitch.
   always_comb begin
      s_ready_d  = state_d inside {ST_LEN_HI, ST_LEN_LO, ST_BYTE_WAIT, ST_DRAIN};
      busy_d     = !(state_d inside {ST_LEN_HI, ST_LEN_LO});
      shift_en_d = state_d inside {ST_SETUP, ST_BYTE_WAIT, ST_BIT_LO, ST_BIT_HI, ST_TRAIL};
      done_d     = (state_d == ST_DONE);
      prev_parity_d = (state_d == ST_DONE) ? parity_q : prev_parity_q;

      len_hi_d = (state_q == ST_LEN_HI && accept_s) ? s.s_data : len_hi_q;

      if (state_q == ST_LEN_HI && accept_s) begin
         err_d = 1'b0;
      end else if (state_q == ST_LEN_LO && accept_s && !len_ok_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end

      if (state_q == ST_LEN_LO && accept_s && !len_ok_s) begin
         drain_d = len_bytes_s;
      end else if (state_q == ST_DRAIN && accept_s) begin
         drain_d = drain_q - ONE_L;
      end else begin
         drain_d = drain_q;
      end

      if (state_d == ST_SETUP) begin
         bits_d = CHAIN_LEN_B;
      end else if (state_d == ST_BIT_HI) begin
         bits_d = bits_q - BIT_W'(1'b1);
      end else begin
         bits_d = bits_q;
      end

      // shift_o is taken on the edge that raises shift_clk, before the chain moves.
      if (state_d == ST_SETUP) begin
         parity_d = 1'b0;
      end else if (state_q == ST_BIT_LO) begin
         parity_d = parity_q ^ shift_o;
      end else begin
         parity_d = parity_q;
      end
   end

   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         len_hi_q      <= 8'd0;
         bits_q        <= BIT_W'(1'b0);
         drain_q       <= ZERO_L;
         parity_q      <= 1'b0;
         prev_parity_q <= 1'b0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         shift_en_q    <= 1'b0;
         s_ready_q     <= 1'b0;
      end else begin
         len_hi_q      <= len_hi_d;
         bits_q        <= bits_d;
         drain_q       <= drain_d;
         parity_q      <= parity_d;
         prev_parity_q <= prev_parity_d;
         err_q         <= err_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         shift_en_q    <= shift_en_d;
         s_ready_q     <= s_ready_d;
      end
   end

   assign s.s_ready   = s_ready_q;
   assign shift_en    = shift_en_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign prev_parity = prev_parity_q;

endmodule

// File: tb/tb_cfg_shift_loader.sv
// Randomised bench for cfg_shift_loader with a behavioural 6-bit chain on the
// shift pins and a reference model of loaded configuration and its parity.
module tb_cfg_shift_loader;
   import cfg_shift_loader_pkg::*;

   localparam int CHAIN_LEN = 6;

   logic cfg_clk = 1'b0;
   logic cfg_rst_n;
   logic shift_clk, shift_en, shift_i, shift_o;
   logic busy, done, err, prev_parity;

   cfg_shift_loader_if sif ();

   cfg_shift_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
      .cfg_clk     (cfg_clk),
      .cfg_rst_n   (cfg_rst_n),
      .s           (sif.slave),
      .shift_clk   (shift_clk),
      .shift_en    (shift_en),
      .shift_i     (shift_i),
      .shift_o     (shift_o),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .prev_parity (prev_parity)
   );

   always #5 cfg_clk = ~cfg_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural chain: two 3-bit buffers, head at bit 0, tail at bit CHAIN_LEN-1.
   logic [CHAIN_LEN-1:0] chain = 6'b110100;
   int   rises = 0;
   int   en_rises = 0;
   int   hold_bad = 0;
   logic last_si = 1'b0;
   logic sent_q[$];

   assign shift_o = chain[CHAIN_LEN-1];

   always @(posedge shift_clk) begin
      chain <= {chain[CHAIN_LEN-2:0], shift_i};
      rises++;
      sent_q.push_back(shift_i);
   end

   always @(posedge shift_en) en_rises++;

   always @(negedge cfg_clk) begin
      if (cfg_rst_n && shift_clk && (shift_i !== last_si)) hold_bad++;
      last_si <= shift_i;
   end

   logic [CHAIN_LEN-1:0] exp_cfg;
   bit                   exp_known;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   task automatic push(input logic [7:0] b, output time t_acc);
      int n;
      sif.s_data  = b;
      sif.s_valid = 1'b1;
      n = 0;
      t_acc = 0;
      while (sif.s_ready !== 1'b1 && n < 200) begin
         @(negedge cfg_clk);
         n++;
      end
      n_cmp++;
      if (n >= 200) begin
         n_bad++;
         $display("FAIL push_timeout: byte %h s_ready=%b after %0d cycles, required 1", b, sif.s_ready, n);
      end else begin
         @(posedge cfg_clk);
         t_acc = $time;
         @(negedge cfg_clk);
      end
      sif.s_valid = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] b, input int stall);
      time t_hdr, t_tmp;
      int r0, e0, q0, lat, exp_lat;
      bit seen;
      logic [CHAIN_LEN-1:0] exp_bits, got_bits;
      exp_bits = b[7 -: CHAIN_LEN];
      r0 = rises;
      e0 = en_rises;
      q0 = sent_q.size();
      push(8'h00, t_tmp);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: err=%b after header byte, required 0", err);
      end
      push(8'h06, t_hdr);
      if (stall > 0) begin
         for (int i = 0; i <= stall; i++) begin
            @(negedge cfg_clk);
            if (i >= 1) begin
               n_cmp++;
               if ({shift_en, shift_clk} !== 2'b10) begin
                  n_bad++;
                  $display("FAIL stall_hold: shift_en/shift_clk=%b%b, required 10", shift_en, shift_clk);
               end
            end
         end
      end
      push(b, t_tmp);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!seen) begin
            @(negedge cfg_clk);
            seen = done;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL done_timeout: no done pulse within 200 cycles, required one");
      end else begin
         lat = int'(($time - 5 - t_hdr) / 10);
         exp_lat = 2 * CHAIN_LEN + 3 + stall;
         n_cmp++;
         if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL done_latency: %0d cycles, required %0d", lat, exp_lat);
         end
         if (exp_known) begin
            n_cmp++;
            if (prev_parity !== ^exp_cfg) begin
               n_bad++;
               $display("FAIL prev_parity: %b, required %b (old config %b)", prev_parity, ^exp_cfg, exp_cfg);
            end
         end
         n_cmp++;
         if ({shift_en, err, busy} !== 3'b001) begin
            n_bad++;
            $display("FAIL done_status: shift_en/err/busy=%b%b%b, required 001", shift_en, err, busy);
         end
         for (int i = 0; i < CHAIN_LEN; i++) begin
            got_bits[CHAIN_LEN-1-i] = (q0 + i < sent_q.size()) ? sent_q[q0+i] : 1'bx;
         end
         n_cmp++;
         if (rises - r0 != CHAIN_LEN || got_bits !== exp_bits) begin
            n_bad++;
            $display("FAIL shift_seq: %0d rises bits %b, required %0d rises bits %b", rises - r0, got_bits, CHAIN_LEN, exp_bits);
         end
         n_cmp++;
         if (chain !== exp_bits) begin
            n_bad++;
            $display("FAIL chain_content: head=%b tail=%b, required head=%b tail=%b", chain[2:0], chain[5:3], exp_bits[2:0], exp_bits[5:3]);
         end
         n_cmp++;
         if (hold_bad != 0 || en_rises - e0 != 1) begin
            n_bad++;
            $display("FAIL shift_timing: %0d shift_i changes under shift_clk, %0d shift_en rises, required 0 and 1", hold_bad, en_rises - e0);
         end
         @(negedge cfg_clk);
         n_cmp++;
         if ({done, busy, sif.s_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL done_pulse: done/busy/s_ready=%b%b%b, required 001", done, busy, sif.s_ready);
         end
      end
      exp_cfg   = exp_bits;
      exp_known = 1'b1;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge cfg_clk);
      n_cmp++;
      if ({sif.s_ready, shift_clk, shift_en, shift_i, busy, done, err, prev_parity} !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_values: %b, required 00000000",
                  {sif.s_ready, shift_clk, shift_en, shift_i, busy, done, err, prev_parity});
      end
      cfg_rst_n = 1'b1;
      @(negedge cfg_clk);
      n_cmp++;
      if ({sif.s_ready, busy, shift_en} !== 3'b100) begin
         n_bad++;
         $display("FAIL after_reset: s_ready/busy/shift_en=%b%b%b, required 100", sif.s_ready, busy, shift_en);
      end
   endtask

   task automatic test_spec_vectors;
      do_load(8'hB4, 0);
      do_load(8'h00, 0);
      do_load(8'hB8, 0);
      do_load(8'($urandom), 0);
   endtask

   task automatic test_stall;
      do_load(8'($urandom), 5);
      for (int k = 0; k < 3; k++) do_load(8'($urandom), int'($urandom_range(1, 6)));
   endtask

   task automatic test_length_error(input logic [15:0] len);
      time t;
      int nbytes, r0, e0;
      nbytes = int'(ceil_div8(len));
      r0 = rises;
      e0 = en_rises;
      push(len[15:8], t);
      push(len[7:0], t);
      n_cmp++;
      if ({err, busy, sif.s_ready} !== {1'b1, nbytes != 0, 1'b1}) begin
         n_bad++;
         $display("FAIL len_err: L=%0d err/busy/s_ready=%b%b%b, required 1%b1", len, err, busy, sif.s_ready, nbytes != 0);
      end
      for (int i = 0; i < nbytes; i++) begin
         push(8'($urandom), t);
         n_cmp++;
         if (busy !== (i != nbytes - 1)) begin
            n_bad++;
            $display("FAIL drain_count: L=%0d after %0d bytes busy=%b, required %b", len, i + 1, busy, i != nbytes - 1);
         end
      end
      n_cmp++;
      if (rises != r0 || en_rises != e0 || err !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_quiet: %0d shift_clk rises %0d shift_en rises err=%b, required 0 0 1", rises - r0, en_rises - e0, err);
      end
   endtask

   task automatic test_reset_mid_load;
      time t;
      int n;
      push(8'h00, t);
      push(8'h06, t);
      push(8'hFC, t);
      n = 0;
      while (shift_clk !== 1'b1 && n < 20) begin
         @(negedge cfg_clk);
         n++;
      end
      n_cmp++;
      if ({shift_clk, shift_en, shift_i} !== 3'b111) begin
         n_bad++;
         $display("FAIL reach_bit_hi: shift_clk/en/i=%b%b%b, required 111", shift_clk, shift_en, shift_i);
      end
      #2 cfg_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({shift_clk, shift_en, shift_i, sif.s_ready, busy} !== 5'd0) begin
         n_bad++;
         $display("FAIL async_reset: shift_clk/en/i/s_ready/busy=%b%b%b%b%b, required 00000",
                  shift_clk, shift_en, shift_i, sif.s_ready, busy);
      end
      exp_known = 1'b0;
      repeat (2) @(negedge cfg_clk);
      cfg_rst_n = 1'b1;
      @(negedge cfg_clk);
      n_cmp++;
      if ({sif.s_ready, err, prev_parity} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_recover: s_ready/err/prev_parity=%b%b%b, required 100", sif.s_ready, err, prev_parity);
      end
      do_load(8'($urandom), 0);
      do_load(8'($urandom), 0);
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 6; k++) do_load(8'($urandom), (k % 2 == 0) ? 0 : int'($urandom_range(0, 3)));
   endtask

   initial begin
      logic [15:0] bad_len;
      cfg_rst_n   = 1'b0;
      sif.s_valid = 1'b0;
      sif.s_data  = 8'h00;
      exp_cfg     = 6'b110100;
      exp_known   = 1'b1;

      test_reset;
      test_spec_vectors;
      test_stall;
      test_length_error(16'd9);
      do_load(8'($urandom), 0);
      test_length_error(16'd0);
      do_load(8'($urandom), 0);
      test_length_error(16'h0106);
      test_length_error(16'd7);
      test_length_error(16'd5);
      for (int k = 0; k < 4; k++) begin
         bad_len = 16'($urandom_range(0, 40));
         if (bad_len == 16'd6) bad_len = 16'd17;
         test_length_error(bad_len);
      end
      do_load(8'($urandom), 0);
      test_reset_mid_load;
      test_back_to_back;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
